// File: rtl/pio_in_edge_irq.sv
// Parametrised Avalon-MM input PIO: synchronised inputs, per-bit edge capture
// with write-1-to-clear, interrupt mask and a level interrupt output.
module pio_in_edge_irq #(
    parameter int              WIDTH       = 4,
    parameter int              SYNC_STAGES = 2,
    parameter int              EDGE_TYPE   = 0,
    parameter int              IRQ_MODE    = 1,
    parameter logic [WIDTH-1:0] RESET_MASK = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] data_s;
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] edgecapture;
    logic [WIDTH-1:0] irqmask;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] det;
    logic [WIDTH-1:0] clr;
    logic [31:0]      rd_mux;
    logic             wr_en;

    assign data_s = sync_q[SYNC_STAGES-1];
    assign wr_en  = chipselect & ~write_n;

    // Synchroniser chain plus one extra flop holding the previous sample.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
            prev <= '0;
        end else begin
            sync_q[0] <= in_port;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            prev <= data_s;
        end
    end

    always_comb begin
        rise = data_s & ~prev;
        fall = ~data_s & prev;
        case (EDGE_TYPE)
            0:       det = rise;
            1:       det = fall;
            default: det = rise | fall;
        endcase
    end

    always_comb begin
        clr = '0;
        if (wr_en && address == 2'd3) clr = writedata[WIDTH-1:0];
    end

    // Set is ORed in after the clear so a coinciding edge keeps the bit.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            edgecapture <= '0;
            irqmask     <= RESET_MASK;
        end else begin
            edgecapture <= (edgecapture & ~clr) | det;
            if (wr_en && address == 2'd2) irqmask <= writedata[WIDTH-1:0];
        end
    end

    always_comb begin
        rd_mux = '0;
        case (address)
            2'd0:    rd_mux[WIDTH-1:0] = data_s;
            2'd2:    rd_mux[WIDTH-1:0] = irqmask;
            2'd3:    rd_mux[WIDTH-1:0] = edgecapture;
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) readdata <= '0;
        else          readdata <= rd_mux;
    end

    generate
        if (IRQ_MODE == 1) begin : g_irq_edge
            assign irq = |(edgecapture & irqmask);
        end else begin : g_irq_level
            assign irq = |(data_s & irqmask);
        end
        if (WIDTH < 32) begin : g_unused
            logic unused_wdata;
            assign unused_wdata = ^writedata[31:WIDTH];
        end
    endgenerate

endmodule
